// File: rtl/add_n_pkg.sv
// Shared helpers for the N-input add/accumulate/clip datapath: width derivation
// and signed saturation, used by the RTL and by the bench.
package add_n_pkg;

   localparam int unsigned SAT_W = 64;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned tree_width(input int unsigned w, input int unsigned n);
      return w + clog2(n);
   endfunction

   function automatic int unsigned acc_width(input int unsigned w, input int unsigned n,
                                             input int unsigned len_w);
      return tree_width(w, n) + len_w;
   endfunction

   // Clamp a wide signed value into the w-bit two's complement range.
   function automatic logic signed [SAT_W-1:0] sat_to_width(input logic signed [SAT_W-1:0] v,
                                                            input int unsigned w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/add_n_and_clip_acc_tree.sv
// Registered pairwise adder tree over NUM_IN signed channels with a matching
// valid pipeline; NUM_IN=1 degenerates to a wire.
module add_n_tree
   import add_n_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned NUM_IN = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_IN*WIDTH-1:0]                in_i,
   input  logic                                   valid_i,
   output logic [tree_width(WIDTH, NUM_IN)-1:0]   tree_sum_o,
   output logic                                   tree_valid_o
);
   localparam int unsigned L  = clog2(NUM_IN);
   localparam int unsigned TW = tree_width(WIDTH, NUM_IN);

   if (L == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign tree_sum_o     = in_i;
      assign tree_valid_o   = valid_i;
   end else begin : g_tree
      // Every level is held at the final width TW; the sums always fit.
      logic signed [TW-1:0] leaf_c [NUM_IN];
      logic signed [TW-1:0] src_c  [L][NUM_IN];
      logic signed [TW-1:0] lvl_d  [L][NUM_IN];
      logic signed [TW-1:0] lvl_q  [L][NUM_IN];
      logic [L-1:0]         vld_q;

      always_comb begin
         int n;
         int ia;
         int ib;
         for (int k = 0; k < NUM_IN; k++) begin
            leaf_c[k]   = TW'(signed'(in_i[k*WIDTH +: WIDTH]));
            src_c[0][k] = leaf_c[k];
         end
         for (int j = 1; j < L; j++) begin
            for (int k = 0; k < NUM_IN; k++) src_c[j][k] = lvl_q[j-1][k];
         end
         for (int j = 0; j < L; j++) begin
            n = (NUM_IN + (1 << j) - 1) >> j;
            for (int k = 0; k < NUM_IN; k++) begin
               ia = (2*k     < NUM_IN) ? 2*k     : 0;
               ib = (2*k + 1 < NUM_IN) ? 2*k + 1 : 0;
               lvl_d[j][k] = '0;
               if (2*k < n)     lvl_d[j][k] = src_c[j][ia];
               if (2*k + 1 < n) lvl_d[j][k] = lvl_d[j][k] + src_c[j][ib];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= '0;
            for (int j = 0; j < L; j++) begin
               for (int k = 0; k < NUM_IN; k++) lvl_q[j][k] <= '0;
            end
         end else begin
            vld_q <= L'({vld_q, valid_i});
            lvl_q <= lvl_d;
         end
      end

      assign tree_sum_o   = lvl_q[L-1][0];
      assign tree_valid_o = vld_q[L-1];
   end

endmodule

// File: rtl/add_n_and_clip_acc.sv
// N-input registered add, optional windowed accumulate, saturate to WIDTH.
// Define ADD_N_CLIP_FLAG_EN to add the registered 'clipped' output.
module add_n_and_clip_acc
   import add_n_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned NUM_IN    = 4,
   parameter int unsigned ACC_LEN_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_IN*WIDTH-1:0]   in,
   input  logic                      strobe_in,
   input  logic [ACC_LEN_W-1:0]      acc_len,
   output logic [WIDTH-1:0]          sum,
   output logic                      strobe_out
`ifdef ADD_N_CLIP_FLAG_EN
   ,
   output logic                      clipped
`endif
);
   localparam int unsigned TW = tree_width(WIDTH, NUM_IN);
   localparam int unsigned AW = acc_width(WIDTH, NUM_IN, ACC_LEN_W);

   logic [TW-1:0]            tree_sum;
   logic                     tree_valid;

   logic [ACC_LEN_W-1:0]     cnt_q, cnt_d;
   logic [ACC_LEN_W-1:0]     win_len_q, win_len_d;
   logic [ACC_LEN_W-1:0]     len_c;
   logic signed [AW-1:0]     acc_q, acc_d;
   logic signed [AW-1:0]     samp_c, total_c, dump_val_c;
   logic                     dump_c;
   logic signed [SAT_W-1:0]  wide_c, sat_c;
   logic [WIDTH-1:0]         sum_q, sum_d;
   logic                     strobe_q, strobe_d;

   add_n_tree #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_tree (
      .clk          (clk),
      .rst          (rst),
      .in_i         (in),
      .valid_i      (strobe_in),
      .tree_sum_o   (tree_sum),
      .tree_valid_o (tree_valid)
   );

   // Window control: the window length is captured on the first sample of a window.
   always_comb begin
      cnt_d      = cnt_q;
      win_len_d  = win_len_q;
      acc_d      = acc_q;
      dump_c     = 1'b0;
      samp_c     = AW'(signed'(tree_sum));
      total_c    = acc_q + samp_c;
      dump_val_c = samp_c;
      len_c      = (cnt_q == '0) ? acc_len : win_len_q;
      if (tree_valid) begin
         if (cnt_q == '0) win_len_d = acc_len;
         if (len_c <= ACC_LEN_W'(1)) begin
            dump_c = 1'b1;
         end else if (cnt_q == len_c - ACC_LEN_W'(1)) begin
            dump_c     = 1'b1;
            dump_val_c = total_c;
            acc_d      = '0;
            cnt_d      = '0;
         end else begin
            acc_d = total_c;
            cnt_d = cnt_q + ACC_LEN_W'(1);
         end
      end
      wide_c   = SAT_W'(dump_val_c);
      sat_c    = sat_to_width(wide_c, WIDTH);
      sum_d    = dump_c ? WIDTH'(sat_c) : sum_q;
      strobe_d = dump_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         win_len_q <= '0;
         acc_q     <= '0;
         sum_q     <= '0;
         strobe_q  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         win_len_q <= win_len_d;
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         strobe_q  <= strobe_d;
      end
   end

   assign sum        = sum_q;
   assign strobe_out = strobe_q;

`ifdef ADD_N_CLIP_FLAG_EN
   logic clipped_q, clipped_d;

   always_comb begin
      clipped_d = clipped_q;
      if (dump_c) clipped_d = (sat_c != wide_c);
   end

   always_ff @(posedge clk) begin
      if (rst) clipped_q <= 1'b0;
      else     clipped_q <= clipped_d;
   end

   assign clipped = clipped_q;
`endif

endmodule
